// File: rtl/n64_vdata_gen.sv
// N64 VI-style video bus source: nVDSYNC plus 7-bit VD, one sync nibble and R/G/B per pixel.
// NTSC/PAL timing, progressive or interlaced, fixed test patterns.
module n64_vdata_gen #(
    parameter int unsigned H_TOTAL_NTSC = 773,
    parameter int unsigned H_TOTAL_PAL  = 794,
    parameter int unsigned V_TOTAL_NTSC = 263,
    parameter int unsigned V_TOTAL_PAL  = 313,
    parameter int unsigned HSYNC_LEN    = 57,
    parameter int unsigned CLAMP_OFS    = 8,
    parameter int unsigned CLAMP_LEN    = 16,
    parameter int unsigned VSYNC_LINES  = 3,
    parameter int unsigned HSTART       = 128,
    parameter int unsigned HACTIVE      = 640,
    parameter int unsigned VSTART_NTSC  = 16,
    parameter int unsigned VSTART_PAL   = 20,
    parameter int unsigned VACTIVE_NTSC = 240,
    parameter int unsigned VACTIVE_PAL  = 288
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       en_i,
    input  logic       palmode_i,
    input  logic       interlaced_i,
    input  logic [1:0] pattern_i,
    output logic       nVDSYNC_o,
    output logic [6:0] VD_o,
    output logic       field_o,
    output logic       frame_start_o
);

    typedef enum logic [1:0] {PH_SYNC, PH_R, PH_G, PH_B} phase_t;
    typedef enum logic [1:0] {PAT_BLACK, PAT_WHITE, PAT_BARS, PAT_RAMP} pattern_t;

    localparam logic [9:0] HT_N      = 10'(H_TOTAL_NTSC);
    localparam logic [9:0] HT_P      = 10'(H_TOTAL_PAL);
    localparam logic [8:0] VT_N      = 9'(V_TOTAL_NTSC);
    localparam logic [8:0] VT_P      = 9'(V_TOTAL_PAL);
    localparam logic [9:0] HS_LEN    = 10'(HSYNC_LEN);
    localparam logic [9:0] CL_START  = 10'(HSYNC_LEN + CLAMP_OFS);
    localparam logic [9:0] CL_END    = 10'(HSYNC_LEN + CLAMP_OFS + CLAMP_LEN);
    localparam logic [8:0] VS_LINES  = 9'(VSYNC_LINES);
    localparam logic [9:0] HA_START  = 10'(HSTART);
    localparam logic [9:0] HA_END    = 10'(HSTART + HACTIVE);
    localparam logic [8:0] VA_N      = 9'(VSTART_NTSC);
    localparam logic [8:0] VA_P      = 9'(VSTART_PAL);
    localparam logic [8:0] VA_END_N  = 9'(VSTART_NTSC + VACTIVE_NTSC);
    localparam logic [8:0] VA_END_P  = 9'(VSTART_PAL + VACTIVE_PAL);

    phase_t     ph, ph_nx;
    logic [9:0] h, h_nx;
    logic [8:0] v, v_nx;
    logic       field, field_nx;
    logic       pal_q, il_q;
    pattern_t   pat_q;

    logic       at_origin, pal_eff, il_eff;
    pattern_t   pat_eff;
    logic [9:0] h_total, half, hx;
    logic [8:0] v_total, va_start, va_end;
    logic [2:0] bar;
    logic       bar_on, vs_low, n_hs, n_cl, n_vs, n_cs, active;
    logic [6:0] level, vd_nx;

    always_comb begin
        // Modes bypass the latch at field start so pixel 0 already uses the new values.
        at_origin = (ph == PH_SYNC) && (h == '0) && (v == '0);
        pal_eff   = at_origin ? palmode_i : pal_q;
        il_eff    = at_origin ? interlaced_i : il_q;
        pat_eff   = at_origin ? pattern_t'(pattern_i) : pat_q;

        h_total  = pal_eff ? HT_P : HT_N;
        v_total  = pal_eff ? VT_P : VT_N;
        va_start = pal_eff ? VA_P : VA_N;
        va_end   = pal_eff ? VA_END_P : VA_END_N;
        half     = h_total >> 1;

        ph_nx    = PH_SYNC;
        h_nx     = h;
        v_nx     = v;
        field_nx = field;
        case (ph)
            PH_SYNC: ph_nx = PH_R;
            PH_R:    ph_nx = PH_G;
            PH_G:    ph_nx = PH_B;
            default: begin
                ph_nx = PH_SYNC;
                if (h == h_total - 10'd1) begin
                    h_nx = '0;
                    if (v == v_total - 9'd1) begin
                        v_nx     = '0;
                        field_nx = il_eff ? ~field : 1'b0;
                    end else begin
                        v_nx = v + 9'd1;
                    end
                end else begin
                    h_nx = h + 10'd1;
                end
            end
        endcase

        n_hs = !(h < HS_LEN);
        n_cl = !((h >= CL_START) && (h < CL_END));
        if (!field)
            vs_low = (v < VS_LINES);
        else
            vs_low = ((v == '0) && (h >= half)) || ((v != '0) && (v < VS_LINES)) ||
                     ((v == VS_LINES) && (h < half));
        n_vs = !vs_low;
        // Serrated csync keeps a falling edge at h=0 on every vsync line.
        n_cs = n_vs ? n_hs : (h >= h_total - HS_LEN);

        active = (h >= HA_START) && (h < HA_END) && (v >= va_start) && (v < va_end);
        hx     = h - HA_START;
        bar    = 3'(hx / 10'd80);
        case (ph)
            PH_R:    bar_on = ~bar[2];
            PH_G:    bar_on = ~bar[1];
            default: bar_on = ~bar[0];
        endcase
        case (pat_eff)
            PAT_WHITE: level = 7'h7F;
            PAT_BARS:  level = bar_on ? 7'h7F : 7'h00;
            PAT_RAMP:  level = hx[9:3];
            default:   level = '0;
        endcase

        if (ph == PH_SYNC)
            vd_nx = {3'b000, n_vs, n_cl, n_hs, n_cs};
        else
            vd_nx = active ? level : '0;
    end

    always_ff @(posedge VCLK) begin
        if (RST || !en_i) begin
            ph            <= PH_SYNC;
            h             <= '0;
            v             <= '0;
            field         <= 1'b0;
            pal_q         <= palmode_i;
            il_q          <= interlaced_i;
            pat_q         <= pattern_t'(pattern_i);
            nVDSYNC_o     <= 1'b1;
            VD_o          <= '0;
            field_o       <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            ph            <= ph_nx;
            h             <= h_nx;
            v             <= v_nx;
            field         <= field_nx;
            pal_q         <= pal_eff;
            il_q          <= il_eff;
            pat_q         <= pat_eff;
            nVDSYNC_o     <= (ph != PH_SYNC);
            VD_o          <= vd_nx;
            field_o       <= field;
            frame_start_o <= at_origin;
        end
    end

endmodule

// File: tb/tb_n64_vdata_gen.sv
// Directed bench for n64_vdata_gen: real line timing, shortened fields so whole fields fit.
module tb_n64_vdata_gen;

    logic       VCLK = 1'b0;
    logic       RST = 1'b1;
    logic       en_i = 1'b0;
    logic       palmode_i = 1'b0;
    logic       interlaced_i = 1'b0;
    logic [1:0] pattern_i = 2'd0;
    logic       nVDSYNC_o;
    logic [6:0] VD_o;
    logic       field_o;
    logic       frame_start_o;

    always #5 VCLK = ~VCLK;

    n64_vdata_gen #(
        .V_TOTAL_NTSC(5),
        .V_TOTAL_PAL(6),
        .VSTART_NTSC(2),
        .VSTART_PAL(3),
        .VACTIVE_NTSC(2),
        .VACTIVE_PAL(2)
    ) dut (
        .VCLK(VCLK),
        .RST(RST),
        .en_i(en_i),
        .palmode_i(palmode_i),
        .interlaced_i(interlaced_i),
        .pattern_i(pattern_i),
        .nVDSYNC_o(nVDSYNC_o),
        .VD_o(VD_o),
        .field_o(field_o),
        .frame_start_o(frame_start_o)
    );

    int checks = 0, errors = 0;
    int cyc = 0, hs_cyc = 0, vs_cyc = 0, lin = 0, pix = 0, phs = 0;
    int hs_gap = 0, vs_gap = 0, vs_h = 0, hs_between = 0, lines_between = 0, cs_bad = 0;
    bit hs_f, vs_f, cs_f, prog_mon = 1'b0;
    logic [3:0]  prev = 4'hF;
    logic [20:0] rgb;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One VCLK; tracks falling sync edges and the bench's own line/pixel position.
    task automatic step();
        @(negedge VCLK);
        cyc++;
        hs_f = 1'b0; vs_f = 1'b0; cs_f = 1'b0;
        if (nVDSYNC_o === 1'b0) begin
            hs_f = prev[1] & ~VD_o[1];
            vs_f = prev[3] & ~VD_o[3];
            cs_f = prev[0] & ~VD_o[0];
            prev = VD_o[3:0];
        end
        if (hs_f) begin
            hs_gap = cyc - hs_cyc;
            hs_cyc = cyc;
            if (!vs_f) begin
                hs_between++;
                lin++;
            end
        end
        if (vs_f) begin
            vs_gap        = cyc - vs_cyc;
            vs_cyc        = cyc;
            vs_h          = (cyc - hs_cyc) / 4;
            lines_between = hs_between;
            hs_between    = 0;
            lin           = 0;
        end
        if (prog_mon && (hs_f != cs_f)) cs_bad++;
        pix = (cyc - hs_cyc) / 4;
        phs = (cyc - hs_cyc) % 4;
    endtask

    task automatic seek(int l, int p, int q);
        for (int n = 0; n < 40000; n++) begin
            if (lin == l && pix == p && phs == q) return;
            step();
        end
        check("seek_timeout", 0, 1);
    endtask

    task automatic wait_vs();
        for (int n = 0; n < 25000; n++) begin
            step();
            if (vs_f) return;
        end
        check("vs_timeout", 0, 1);
    endtask

    task automatic wait_hs();
        for (int n = 0; n < 5000; n++) begin
            step();
            if (hs_f) return;
        end
        check("hs_timeout", 0, 1);
    endtask

    task automatic rgb_at(int l, int p, output logic [20:0] val);
        seek(l, p, 1);
        val[20:14] = VD_o;
        step();
        val[13:7] = VD_o;
        step();
        val[6:0] = VD_o;
    endtask

    initial begin
        // Reset and disable keep the bus idle
        repeat (4) begin
            step();
            check("rst_nvdsync", int'(nVDSYNC_o), 1);
            check("rst_vd", int'(VD_o), 0);
        end
        en_i = 1'b0;
        step();
        RST = 1'b0;
        repeat (4) begin
            step();
            check("dis_nvdsync", int'(nVDSYNC_o), 1);
            check("dis_vd", int'(VD_o), 0);
            check("dis_fs", int'(frame_start_o), 0);
        end

        // NTSC progressive, colour bars; modes switched mid-field
        palmode_i = 1'b0; interlaced_i = 1'b0; pattern_i = 2'd2;
        prev = 4'hF; prog_mon = 1'b1; en_i = 1'b1;
        step();
        check("start_fs", int'(frame_start_o), 1);
        check("start_nvdsync", int'(nVDSYNC_o), 0);
        check("start_nib", int'(VD_o), 7'h04);
        check("start_field", int'(field_o), 0);
        check("start_vs_h", vs_h, 0);
        step();
        check("ph1_fs", int'(frame_start_o), 0);
        check("ph1_nvdsync", int'(nVDSYNC_o), 1);

        seek(1, 10, 0); check("hs_gap_ntsc", hs_gap, 3092);
        seek(1, 56, 0); check("nib_h56", int'(VD_o), 7'h04);
        seek(1, 57, 0); check("nib_h57", int'(VD_o), 7'h06);
        seek(1, 65, 0); check("nib_clamp", int'(VD_o), 7'h02);
        seek(1, 81, 0); check("nib_clamp_end", int'(VD_o), 7'h06);
        seek(1, 716, 0); check("nib_serr", int'(VD_o), 7'h07);
        rgb_at(1, 128, rgb); check("above_win", int'(rgb), 0);
        rgb_at(2, 127, rgb); check("bar_h127", int'(rgb), 0);
        rgb_at(2, 128, rgb); check("bar_h128", int'(rgb), int'({7'h7F, 7'h7F, 7'h7F}));
        rgb_at(2, 208, rgb); check("bar_h208", int'(rgb), int'({7'h7F, 7'h7F, 7'h00}));
        rgb_at(2, 288, rgb); check("bar_h288", int'(rgb), int'({7'h7F, 7'h00, 7'h7F}));
        rgb_at(2, 767, rgb); check("bar_h767", int'(rgb), 0);
        seek(2, 400, 0); check("nib_vs_line2", int'(VD_o), 7'h06);

        seek(3, 10, 0);
        palmode_i = 1'b1; pattern_i = 2'd3;
        rgb_at(3, 208, rgb); check("pat_latched", int'(rgb), int'({7'h7F, 7'h7F, 7'h00}));
        seek(3, 400, 0); check("nib_vs_over", int'(VD_o), 7'h0F);
        wait_vs();
        check("ntsc_field_cyc", vs_gap, 15460);
        check("ntsc_hs_between", lines_between, 4);
        check("ntsc_vs_h", vs_h, 0);
        check("ntsc_field", int'(field_o), 0);

        // Next field picks up PAL timing and ramp
        seek(1, 10, 0); check("hs_gap_pal", hs_gap, 3176);
        rgb_at(2, 145, rgb); check("pal_above_win", int'(rgb), 0);
        rgb_at(3, 145, rgb); check("ramp_h145", int'(rgb), int'({7'd2, 7'd2, 7'd2}));
        rgb_at(4, 767, rgb); check("ramp_h767", int'(rgb), int'({7'd79, 7'd79, 7'd79}));
        wait_vs();
        check("pal_field_cyc", vs_gap, 19056);
        check("pal_hs_between", lines_between, 5);
        check("pal_vs_h", vs_h, 0);
        check("pal_field", int'(field_o), 0);
        check("cs_every_line", cs_bad, 0);
        prog_mon = 1'b0;

        // PAL interlaced, white
        RST = 1'b1; palmode_i = 1'b1; interlaced_i = 1'b1; pattern_i = 2'd1;
        step(); step();
        check("rst2_nvdsync", int'(nVDSYNC_o), 1);
        check("rst2_vd", int'(VD_o), 0);
        RST = 1'b0; prev = 4'hF;
        step();
        check("il_fs", int'(frame_start_o), 1);
        check("il_field0", int'(field_o), 0);
        check("il_vs_h0", vs_h, 0);
        rgb_at(2, 128, rgb); check("white_above", int'(rgb), 0);
        rgb_at(3, 128, rgb); check("white_h128", int'(rgb), int'({7'h7F, 7'h7F, 7'h7F}));
        wait_vs();
        check("odd_vs_h", vs_h, 397);
        check("odd_field", int'(field_o), 1);
        check("odd_vs_gap", vs_gap, 20644);

        // Disable mid-line, then restart in NTSC progressive
        seek(1, 300, 0);
        check("odd_field_l1", int'(field_o), 1);
        en_i = 1'b0;
        step();
        check("abort_nvdsync", int'(nVDSYNC_o), 1);
        check("abort_vd", int'(VD_o), 0);
        check("abort_field", int'(field_o), 0);
        repeat (3) step();
        palmode_i = 1'b0; interlaced_i = 1'b0; prev = 4'hF; en_i = 1'b1;
        step();
        check("re_fs", int'(frame_start_o), 1);
        check("re_field", int'(field_o), 0);
        check("re_nib", int'(VD_o), 7'h04);
        step();
        check("re_fs_pulse", int'(frame_start_o), 0);
        wait_hs();
        check("re_hs_gap", hs_gap, 3092);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
